// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution block and its predictor table.
package branch_ctrl_pkg;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly not-taken starting point for every prediction counter
    localparam logic [1:0] BHT_RST = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Two-bit saturating counter step
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11)
            res = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            res = ctr - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters indexed by word PC bits.
// Reads are combinational and see the value before any same-cycle update.
module branch_bht
    import branch_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] rd_pc_i,
    output logic        rd_taken_o,
    input  logic        upd_en_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_pc_bits;

    assign rd_idx     = rd_pc_i[IDX_W+1:2];
    assign upd_idx    = upd_pc_i[IDX_W+1:2];
    assign rd_taken_o = ctr[rd_idx][1];

    // Byte-offset and high PC bits do not take part in indexing
    assign unused_pc_bits = ^{rd_pc_i[31:IDX_W+2], rd_pc_i[1:0],
                              upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

    // Counter storage with saturating update on resolved legal branches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= BHT_RST;
        end else if (upd_en_i) begin
            ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution: decides taken/not-taken from external comparator flags,
// detects mispredicts, redirects fetch and squashes younger instructions.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    input  logic        br_valid_i,
    output logic        br_ready_o,
    input  logic [2:0]  br_funct3_i,
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_imm_i,
    input  logic        br_pred_i,
    output logic        br_unsign_o,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_o,
    output logic [15:0] mispred_cnt_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             taken;
    logic             legal;
    logic             mispredict;
    logic [31:0]      target;

    assign br_unsign_o = br_funct3_i[1];
    assign br_ready_o  = (state_q == ST_IDLE);
    assign flush_o     = (state_q == ST_FLUSH);
    assign accept      = br_valid_i && br_ready_o;
    assign target      = taken ? (br_pc_i + br_imm_i) : (br_pc_i + 32'd4);
    assign mispredict  = accept && legal && (taken != br_pred_i);

    // Branch condition decode from comparator flags
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (br_funct3_i)
            F3_BEQ:         taken = br_equal_i;
            F3_BNE:         taken = !br_equal_i;
            F3_BLT, F3_BLTU: taken = br_less_i;
            F3_BGE, F3_BGEU: taken = !br_less_i;
            default:        legal = 1'b0;
        endcase
    end

    branch_bht #(
        .ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_pc_i    (fetch_pc_i),
        .rd_taken_o (pred_taken_o),
        .upd_en_i   (accept && legal),
        .upd_pc_i   (br_pc_i),
        .upd_taken_i(taken)
    );

    // FSM state and flush down-counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a mispredict holds off new branches for FLUSH_CYCLES cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered redirect/illegal pulses and mispredict statistics
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            illegal_o        <= 1'b0;
            mispred_cnt_o    <= '0;
        end else begin
            redirect_valid_o <= mispredict;
            illegal_o        <= accept && !legal;
            if (mispredict) begin
                redirect_pc_o <= target;
                mispred_cnt_o <= mispred_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: BHT_ENTRIES, 16, number of 2-bit prediction counters (power of 2).
REQ-002 Parameter: FLUSH_CYCLES, 2, cycles the flush stays asserted after a mispredict.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_ni  in  1  async active-low reset.
REQ-006 fetch_pc_i  in  32  PC being fetched, used for prediction lookup.
REQ-007 pred_taken_o  out  1  combinational prediction for fetch_pc_i.
REQ-008 br_valid_i  in  1  branch in EX is valid.
REQ-009 br_ready_o  out  1  block accepts a branch this cycle.
REQ-010 br_funct3_i  in  3  branch funct3.
REQ-011 br_pc_i  in  32  branch PC.
REQ-012 br_imm_i  in  32  sign-extended B-immediate.
REQ-013 br_pred_i  in  1  prediction carried down the pipeline with the branch.
REQ-014 br_unsign_o  out  1  drives the comparator unsigned select.
REQ-015 br_less_i, br_equal_i  in  1 each  comparator results, same cycle.
REQ-016 redirect_valid_o  out  1  one-cycle PC redirect pulse.
REQ-017 redirect_pc_o  out  32  corrected PC.
REQ-018 flush_o  out  1  squash younger IF/ID instructions.
REQ-019 illegal_o  out  1  one-cycle pulse, reserved funct3 accepted.
REQ-020 mispred_cnt_o  out  16  mispredict count, wraps.

Function
REQ-021 br_unsign_o SHALL equal br_funct3_i[1], combinational.
REQ-022 Accept = br_valid_i && br_ready_o; unaccepted branches SHALL have no effect.
REQ-023 Taken: 000 equal; 001 !equal; 100/110 less; 101/111 !less; 010/011 not taken, illegal.
REQ-024 Actual target SHALL be br_pc_i+br_imm_i if taken, else br_pc_i+4, modulo 2^32.
REQ-025 Mispredict = accepted legal branch with taken != br_pred_i; illegal funct3 is never a mispredict.
REQ-026 FSM states: IDLE, FLUSH.
REQ-027 IDLE: br_ready_o=1; on mispredict SHALL, next cycle, enter FLUSH, pulse redirect_valid_o for one cycle with registered target, and assert flush_o.
REQ-028 FLUSH: br_ready_o=0, flush_o=1 for exactly FLUSH_CYCLES cycles (down-counter), then IDLE.
REQ-029 Correct prediction: stay IDLE, no redirect, no flush.
REQ-030 Illegal funct3: illegal_o pulses the next cycle; no redirect, no BHT update.
REQ-031 BHT index = pc[log2(BHT_ENTRIES)+1:2]; pred_taken_o = counter MSB.
REQ-032 Each accepted legal branch SHALL update its counter one cycle later: +1 taken, -1 not taken, saturating at 3 and 0.
REQ-033 Lookup and update of the same index in one cycle SHALL return the pre-update value.
REQ-034 mispred_cnt_o SHALL increment once per mispredict, wrapping 0xFFFF->0x0000.

Reset
REQ-035 On rst_ni low, asynchronously: state IDLE, flush counter 0, all BHT counters 2'b01, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, illegal_o=0, mispred_cnt_o=0.
REQ-036 Reset during FLUSH SHALL abort the flush immediately; the first cycle after release SHALL be IDLE with br_ready_o=1.

Structure
REQ-037 Shared package SHALL hold funct3 constants (BEQ..BGEU), the FSM state enum and the 2'b01 BHT reset value.
REQ-038 The BHT (storage, saturating update, read-before-write) SHALL be one sub-module: branch_bht.
REQ-039 The comparator SHALL stay external; branch_ctrl only drives its select and consumes its results.

Verification
REQ-040 After reset, fetch_pc_i=0x100 -> pred_taken_o=0; every index reads 2'b01.
REQ-041 BEQ, pc=0x200, imm=0x40, equal=1, pred=0 -> next cycle redirect_valid_o=1, redirect_pc_o=0x240; flush_o=1 for 2 cycles; br_ready_o=0 during both; mispred_cnt_o=1.
REQ-042 BLTU, pc=0x300, less=0, pred=0 -> no redirect, no flush, br_unsign_o=1, counter[0] saturates at 0 after two such branches.
REQ-043 BGE taken, pred=1, four times at one PC -> counter 1->2->3->3, no redirect; br_valid_i during FLUSH is ignored.
REQ-044 funct3=010 accepted -> illegal_o pulse, no redirect, BHT unchanged; pc=0xFFFFFFFC not-taken mispredict -> redirect_pc_o=0x00000000.
REQ-045 rst_ni low in second FLUSH cycle -> flush_o=0 immediately; after release br_ready_o=1, mispred_cnt_o=0.
